// File: rtl/bcd_display_feeder.sv
// bcd_display_feeder
// Sequential 16-bit binary to 4-digit packed BCD converter using double dabble.
// It accepts one value over a valid/ready handshake. It performs 14 shift-and-add-3
// steps and then publishes the result on data_out with a one-cycle out_valid pulse.
// Values above 9999 raise ovf and drive an overflow pattern instead of digits.
// Build option: define BCD_FEEDER_OVF_BLANK_EN to show "EEEE" on overflow.
// When it is left undefined, overflow saturates the display at 9999.
module bcd_display_feeder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [15:0] data_out,
    output logic        out_valid,
    output logic        ovf
);

`ifdef BCD_FEEDER_OVF_BLANK_EN
    localparam logic [15:0] OVF_PATTERN = 16'hEEEE;
`else
    localparam logic [15:0] OVF_PATTERN = 16'h9999;
`endif

    // Only 14 bits of input reach the shifter; bits [15:14] matter only for overflow.
    localparam logic [3:0] LAST_SHIFT = 4'd13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] acc_reg, acc_next;
    logic [13:0] bin_reg, bin_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        ovf_pend_reg, ovf_pend_next;
    logic [15:0] data_out_reg, data_out_next;
    logic        ovf_reg, ovf_next;
    logic        out_valid_reg, out_valid_next;
    logic [15:0] acc_adj;

    // Per-nibble add-3 correction, with no carry between nibbles.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
            assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5)
                                        ? acc_reg[gi*4 +: 4] + 4'd3
                                        : acc_reg[gi*4 +: 4];
        end
    endgenerate

    assign in_ready  = (state_reg == IDLE);
    assign data_out  = data_out_reg;
    assign out_valid = out_valid_reg;
    assign ovf       = ovf_reg;

    // State and datapath registers with a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            acc_reg       <= 16'h0000;
            bin_reg       <= 14'h0000;
            cnt_reg       <= 4'd0;
            ovf_pend_reg  <= 1'b0;
            data_out_reg  <= 16'h0000;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            bin_reg       <= bin_next;
            cnt_reg       <= cnt_next;
            ovf_pend_reg  <= ovf_pend_next;
            data_out_reg  <= data_out_next;
            ovf_reg       <= ovf_next;
            out_valid_reg <= out_valid_next;
        end
    end

    // Next-state logic and conversion datapath. The visible outputs change only in DONE.
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        bin_next       = bin_reg;
        cnt_next       = cnt_reg;
        ovf_pend_next  = ovf_pend_reg;
        data_out_next  = data_out_reg;
        ovf_next       = ovf_reg;
        out_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    bin_next      = in_data[13:0];
                    acc_next      = 16'h0000;
                    ovf_pend_next = (in_data > 16'd9999);
                    cnt_next      = 4'd0;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                // Shift {corrected accumulator, binary field} left by one bit (30 bits wide).
                acc_next = {acc_adj[14:0], bin_reg[13]};
                bin_next = {bin_reg[12:0], 1'b0};
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == LAST_SHIFT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_next = 1'b1;
                if (ovf_pend_reg) begin
                    data_out_next = OVF_PATTERN;
                    ovf_next      = 1'b1;
                end else begin
                    data_out_next = acc_reg;
                    ovf_next      = 1'b0;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Self-checking bench for bcd_display_feeder.
// It runs directed cases followed by randomized values.
// Expected digits come from decimal arithmetic on each value.
module tb_bcd_display_feeder;

`ifdef BCD_FEEDER_OVF_BLANK_EN
    localparam logic [15:0] EXP_OVF = 16'hEEEE;
`else
    localparam logic [15:0] EXP_OVF = 16'h9999;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] data_out;
    logic        out_valid;
    logic        ovf;

    int vectors = 0;
    int miscompares = 0;

    bcd_display_feeder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .data_out  (data_out),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits of the value, or the overflow pattern above 9999.
    function automatic logic [15:0] model(input logic [15:0] v);
        int x;
        int r;
        x = int'(v);
        if (x > 9999) return EXP_OVF;
        r = ((x / 1000) % 10) * 4096 + ((x / 100) % 10) * 256 + ((x / 10) % 10) * 16 + (x % 10);
        return r[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until out_valid is seen (bounded), and note if in_ready ever rose while busy.
    // Random in_valid and in_data noise is applied throughout to show that busy-time requests are dropped.
    task automatic wait_result(output int n, output logic busy_ok);
        n = 1;
        busy_ok = 1'b1;
        tick();
        while (!out_valid && n < 40) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid = 1'($urandom);
            in_data  = 16'($urandom);
            tick();
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic convert(input logic [15:0] v, input string tag);
        logic [15:0] exp;
        int          n;
        logic        busy_ok;
        exp = model(v);
        check({tag, ".idle"}, 32'(in_ready), 32'd1);
        in_data  = v;
        in_valid = 1'b1;
        tick();                     // E0: handshake
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        wait_result(n, busy_ok);    // ends just after E15
        check({tag, ".latency"}, 32'(n), 32'd15);
        check({tag, ".busy"}, 32'(busy_ok), 32'd1);
        check({tag, ".data"}, 32'(data_out), 32'(exp));
        check({tag, ".ovf"}, 32'(ovf), 32'(v > 16'd9999));
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        tick();
        check({tag, ".pulse"}, 32'(out_valid), 32'd0);
        check({tag, ".hold"}, 32'(data_out), 32'(exp));
        $display("convert %s: in=%0d data_out=%h ovf=%0b latency=%0d", tag, v, data_out, ovf, n);
    endtask

    initial begin
        int          n;
        logic        seen;
        logic        busy_ok;
        logic [15:0] v;
        logic [15:0] exp_hold;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
        repeat (3) tick();
        check("reset.data", 32'(data_out), 32'h0000);
        check("reset.ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.ovf", 32'(ovf), 32'd0);
        $display("reset: data_out=%h ready=%0b", data_out, in_ready);
        reset_n = 1'b1;
        tick();

        convert(16'd1234, "single");
        convert(16'd0, "zero");
        convert(16'd9999, "max");
        convert(16'd10000, "ovf10000");
        convert(16'd65535, "ovf65535");
        convert(16'd1, "one");

        // Back-to-back with in_valid held high.
        in_data  = 16'd42;
        in_valid = 1'b1;
        tick();                     // E0
        in_data = 16'd5678;
        n = 1;
        tick();
        while (!out_valid && n < 40) begin tick(); n++; end
        check("b2b.lat1", 32'(n), 32'd15);
        check("b2b.data1", 32'(data_out), 32'h0042);
        tick();                     // E16: second value accepted
        in_valid = 1'b0;
        in_data  = 16'd0;
        check("b2b.accept", 32'(in_ready), 32'd0);
        wait_result(n, busy_ok);
        check("b2b.lat2", 32'(n), 32'd15);
        check("b2b.busy2", 32'(busy_ok), 32'd1);
        check("b2b.data2", 32'(data_out), 32'h5678);
        $display("b2b: data_out=%h", data_out);
        tick();

        // Reset mid-conversion.
        in_data  = 16'd8888;
        in_valid = 1'b1;
        tick();                     // E0
        in_valid = 1'b0;
        repeat (6) tick();          // E1..E6
        reset_n = 1'b0;
        tick();                     // E7
        check("midrst.data", 32'(data_out), 32'h0000);
        check("midrst.ready", 32'(in_ready), 32'd1);
        check("midrst.ovf", 32'(ovf), 32'd0);
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("midrst.nopulse", 32'(seen), 32'd0);
        check("midrst.data_after", 32'(data_out), 32'h0000);
        $display("midrst: data_out=%h pulse_seen=%0b", data_out, seen);
        convert(16'd7, "after_rst");

        // Hold the last result while the input data changes with in_valid low.
        convert(16'd305, "hold_src");
        seen = 1'b0;
        exp_hold = 16'h0305;
        for (int i = 0; i < 100; i++) begin
            in_data = 16'($urandom);
            tick();
            if (out_valid || data_out !== exp_hold) seen = 1'b1;
        end
        check("hold.stable", 32'(seen), 32'd0);
        $display("hold: data_out=%h disturbed=%0b", data_out, seen);

        // Randomized values over the full range, with extra weight on 0..9999.
        for (int i = 0; i < 30; i++) begin
            v = (i % 3 == 2) ? 16'($urandom) : 16'($urandom_range(0, 9999));
            convert(v, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
